// File: rtl/hamm_req_sched.sv
// Round-robin scheduler sharing one Hamming encode/check engine among N_REQ requesters.
// Grants one requester at a time, runs a start/done handshake with timeout, returns a tagged response.
module hamm_req_sched #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 8,
    localparam int unsigned IDW    = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      req_op,
    input  logic [N_REQ*DW-1:0]   req_din,
    output logic [N_REQ-1:0]      gnt,
    output logic                  eng_start,
    output logic                  eng_op,
    output logic [DW-1:0]         eng_din,
    input  logic                  eng_done,
    input  logic [DW-1:0]         eng_dout,
    input  logic [1:0]            eng_err,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [DW-1:0]         rsp_data,
    output logic [1:0]            rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy
);

    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               eng_start_q, eng_start_d;
    logic               eng_op_q, eng_op_d;
    logic [DW-1:0]      eng_din_q, eng_din_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [DW-1:0]      rsp_data_q, rsp_data_d;
    logic [1:0]         rsp_err_q, rsp_err_d;
    logic               rsp_timeout_q, rsp_timeout_d;
    logic               busy_q, busy_d;

    logic               arb_found;
    logic [IDW-1:0]     arb_id;
    logic [DW-1:0]      din_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_din
        assign din_arr[g] = req_din[g*DW +: DW];
    end

    // Cyclic first-set search starting at the round-robin pointer
    always_comb begin
        arb_found = 1'b0;
        arb_id    = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            if (!arb_found && req[IDW'((32'(ptr_q) + off) % N_REQ)]) begin
                arb_found = 1'b1;
                arb_id    = IDW'((32'(ptr_q) + off) % N_REQ);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        id_d          = id_q;
        timer_d       = timer_q;
        gnt_d         = '0;
        eng_start_d   = 1'b0;
        eng_op_d      = eng_op_q;
        eng_din_d     = eng_din_q;
        rsp_valid_d   = 1'b0;
        rsp_id_d      = rsp_id_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d     = ISSUE;
                    id_d        = arb_id;
                    eng_op_d    = req_op[arb_id];
                    eng_din_d   = din_arr[arb_id];
                    gnt_d       = N_REQ'(1) << arb_id;
                    eng_start_d = 1'b1;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            // Done has priority over an expiring timer in the same cycle
            WAIT: begin
                if (eng_done) begin
                    rsp_valid_d   = 1'b1;
                    rsp_id_d      = id_q;
                    rsp_data_d    = eng_dout;
                    rsp_err_d     = eng_err;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    rsp_valid_d   = 1'b1;
                    rsp_id_d      = id_q;
                    rsp_data_d    = '0;
                    rsp_err_d     = 2'b00;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                ptr_d   = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + IDW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            id_q          <= '0;
            timer_q       <= '0;
            gnt_q         <= '0;
            eng_start_q   <= 1'b0;
            eng_op_q      <= 1'b0;
            eng_din_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 2'b00;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            id_q          <= id_d;
            timer_q       <= timer_d;
            gnt_q         <= gnt_d;
            eng_start_q   <= eng_start_d;
            eng_op_q      <= eng_op_d;
            eng_din_q     <= eng_din_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign gnt         = gnt_q;
    assign eng_start   = eng_start_q;
    assign eng_op      = eng_op_q;
    assign eng_din     = eng_din_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_hamm_req_sched.sv
// Directed bench for hamm_req_sched: engine model, response scoreboard, grant-order checks.
module tb_hamm_req_sched;

    localparam int N_REQ   = 4;
    localparam int DW      = 16;
    localparam int TIMEOUT = 8;
    localparam int IDW     = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N_REQ-1:0]    req = '0;
    logic [N_REQ-1:0]    req_op = '0;
    logic [N_REQ*DW-1:0] req_din = '0;
    logic [N_REQ-1:0]    gnt;
    logic                eng_start;
    logic                eng_op;
    logic [DW-1:0]       eng_din;
    logic                eng_done = 1'b0;
    logic [DW-1:0]       eng_dout = '0;
    logic [1:0]          eng_err = 2'b00;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [DW-1:0]       rsp_data;
    logic [1:0]          rsp_err;
    logic                rsp_timeout;
    logic                busy;

    hamm_req_sched #(.N_REQ(N_REQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_din(req_din),
        .gnt(gnt), .eng_start(eng_start), .eng_op(eng_op), .eng_din(eng_din),
        .eng_done(eng_done), .eng_dout(eng_dout), .eng_err(eng_err),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [DW-1:0] data;
        logic [1:0]  err;
        logic        to;
        int          cyc;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            tests_run = 0;
    int            tests_failed = 0;
    int            cyc = 0;
    logic [DW-1:0] din_tb [N_REQ];

    // Engine model knobs: latency 0 means never done
    int            eng_lat = 0;
    logic          eng_inv = 1'b0;
    logic [DW-1:0] eng_cfg = '0;
    logic [1:0]    eng_err_cfg = 2'b00;
    logic          eng_armed = 1'b0;
    int            eng_cnt = 0;
    logic [DW-1:0] eng_din_lat = '0;

    logic prev_rsp = 1'b0, prev_gnt = 1'b0, prev_start = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Engine: done is driven during cycle S+eng_lat after the start pulse in cycle S
    always @(negedge clk) begin
        if (eng_start) begin
            eng_armed   = 1'b1;
            eng_cnt     = 0;
            eng_din_lat = eng_din;
        end else if (eng_armed) begin
            eng_cnt++;
        end
        eng_done = 1'b0;
        if (eng_armed && eng_lat != 0 && eng_cnt == eng_lat) begin
            eng_done  = 1'b1;
            eng_armed = 1'b0;
        end
        eng_dout = eng_inv ? ~eng_din_lat : eng_cfg;
        eng_err  = eng_err_cfg;
    end

    // Response monitor and pulse-width checks
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                check("rsp_pulse", 32'(prev_rsp), 32'd0);
                if (sb.size() == 0) begin
                    check("rsp_spurious", 32'(rsp_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_id", 32'(rsp_id), mon_e.id);
                    check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
                    check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                    check("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.to));
                    check("rsp_cycle", cyc, mon_e.cyc);
                end
            end
            if (gnt != '0) check("gnt_pulse", 32'(prev_gnt), 32'd0);
            if (eng_start) check("start_pulse", 32'(prev_start), 32'd0);
        end
        prev_rsp   = rsp_valid;
        prev_gnt   = |gnt;
        prev_start = eng_start;
    end

    task automatic push(input int id, input logic [DW-1:0] data, input logic [1:0] err,
                        input logic to, input int c);
        exp_t e;
        e.id = id; e.data = data; e.err = err; e.to = to; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic wait_gnt(output int id, output int s);
        id = 0;
        s  = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (gnt != '0) begin
                for (int i = 0; i < N_REQ; i++) if (gnt[i]) id = i;
                s = cyc;
                check("gnt_onehot", $countones(gnt), 1);
                check("start_with_gnt", 32'(eng_start), 32'd1);
                check("eng_din", 32'(eng_din), 32'(din_tb[id]));
                check("eng_op", 32'(eng_op), 32'(req_op[id]));
                return;
            end
        end
        check("gnt_wait_expired", 32'(gnt != '0), 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_start"}, 32'(eng_start), 32'd0);
        check({tag, "_eng_op"}, 32'(eng_op), 32'd0);
        check({tag, "_eng_din"}, 32'(eng_din), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_rsp_to"}, 32'(rsp_timeout), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int id, s, prev_s;
        int exp_ids[3];

        din_tb[0] = 16'h0028;
        din_tb[1] = 16'h1111;
        din_tb[2] = 16'h2222;
        din_tb[3] = 16'h3333;
        for (int i = 0; i < N_REQ; i++) req_din[i*DW +: DW] = din_tb[i];

        // Reset state
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Single encode request, done at S+3
        eng_lat = 3; eng_inv = 1'b0; eng_cfg = 16'h0A5C; eng_err_cfg = 2'b00;
        @(negedge clk);
        req = 4'b0001;
        wait_gnt(id, s);
        check("t1_id", id, 0);
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_din", 32'(eng_din), 32'h0028);
        req = 4'b0000;
        push(0, 16'h0A5C, 2'b00, 1'b0, s + 4);
        @(negedge clk);
        check("t1_gnt_off", 32'(gnt), 32'd0);
        check("t1_start_off", 32'(eng_start), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        drain();

        // Fairness with all requesters active from reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        eng_lat = 1; eng_inv = 1'b1; eng_err_cfg = 2'b00;
        req = 4'b1111;
        prev_s = 0;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(id, s);
            check("t2_order", id, k % 4);
            if (k > 0) check("t2_spacing", s - prev_s, 4);
            push(id, ~din_tb[id], 2'b00, 1'b0, s + 2);
            prev_s = s;
            if (k == 4) req = 4'b0000;
        end
        drain();

        // Pointer skip after requester 2 is served
        req = 4'b0100;
        wait_gnt(id, s);
        check("t3_first", id, 2);
        push(id, ~din_tb[id], 2'b00, 1'b0, s + 2);
        req = 4'b1011;
        exp_ids[0] = 3; exp_ids[1] = 0; exp_ids[2] = 1;
        for (int k = 0; k < 3; k++) begin
            wait_gnt(id, s);
            check("t3_order", id, exp_ids[k]);
            push(id, ~din_tb[id], 2'b00, 1'b0, s + 2);
            req[id] = 1'b0;
        end
        drain();

        // Timeout: engine never answers
        eng_lat = 0; eng_inv = 1'b0; eng_cfg = 16'hBEEF;
        req = 4'b1000;
        wait_gnt(id, s);
        check("t4_id", id, 3);
        req = 4'b0000;
        push(3, 16'h0000, 2'b00, 1'b1, s + TIMEOUT + 1);
        repeat (TIMEOUT + 1) @(negedge clk);
        check("t4_valid", 32'(rsp_valid), 32'd1);
        check("t4_busy_resp", 32'(busy), 32'd1);
        @(negedge clk);
        check("t4_busy_drop", 32'(busy), 32'd0);
        drain();

        // Done coincides with the last WAIT cycle: done wins
        eng_lat = TIMEOUT; eng_cfg = 16'h1234; eng_err_cfg = 2'b01;
        req_op[1] = 1'b1;
        req = 4'b0010;
        wait_gnt(id, s);
        check("t5_id", id, 1);
        check("t5_op", 32'(eng_op), 32'd1);
        req = 4'b0000;
        push(1, 16'h1234, 2'b01, 1'b0, s + TIMEOUT + 1);
        drain();

        // Reset during WAIT aborts silently and rewinds the pointer
        req_op[1] = 1'b0;
        eng_lat = 5; eng_inv = 1'b1; eng_err_cfg = 2'b00;
        req = 4'b1000;
        wait_gnt(id, s);
        check("t6_id", id, 3);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        check("t6_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_zero("t6_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t6_no_rsp", 32'(rsp_valid), 32'd0);
        end
        req = 4'b1010;
        wait_gnt(id, s);
        check("t6_after_rst", id, 1);
        push(1, ~din_tb[1], 2'b00, 1'b0, s + 6);
        req = 4'b1000;
        wait_gnt(id, s);
        check("t6_next", id, 3);
        push(3, ~din_tb[3], 2'b00, 1'b0, s + 6);
        req = 4'b0000;
        drain();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hamm_req_sched.md
Name: hamm_req_sched

Overview:
- Round-robin scheduler that shares one Hamming encode/check engine among N_REQ requesters.
- Arbitrates between requests, grants one requester at a time, launches the engine with a start/done handshake, and returns the tagged result.
- Bounds every engine operation with a timeout.
- Sits between requester blocks and the Hamming datapath in the top level.

Parameters:
N_REQ, 4, number of requesters (2..8)
DW, 16, data/codeword width (6-bit payload zero-extended)
TIMEOUT, 8, max WAIT cycles before abort (>=2)
IDW, $clog2(N_REQ), requester id width (derived localparam)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
req  in  N_REQ  request per requester, held until granted
req_op  in  N_REQ  per-requester op: 0 = encode, 1 = check/correct
req_din  in  N_REQ*DW  per-requester data, slice i = [i*DW +: DW]
gnt  out  N_REQ  one-hot grant, one-cycle pulse
eng_start  out  1  engine start pulse
eng_op  out  1  op to engine
eng_din  out  DW  data to engine
eng_done  in  1  engine result valid, one cycle
eng_dout  in  DW  engine result
eng_err  in  2  engine status: 00 ok, 01 corrected, 10 uncorrectable
rsp_valid  out  1  response pulse
rsp_id  out  IDW  requester index of response
rsp_data  out  DW  result data
rsp_err  out  2  result status
rsp_timeout  out  1  1 = operation aborted by timeout
busy  out  1  high when state != IDLE

Behaviour:
- All outputs are registered. busy is decoded from the state register.
- On reset (rst_n low, async):
  - state = IDLE, rr pointer = 0, timer = 0.
  - gnt, eng_start, eng_op, eng_din, rsp_valid, rsp_id, rsp_data, rsp_err, rsp_timeout, busy all 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req != 0, select the first set bit at or after ptr, searching cyclically (ptr, ptr+1, ..., wrapping to ptr-1).
  - Latch id, req_op[id], req_din slice into eng_op / eng_din.
  - Set gnt = onehot(id) and eng_start = 1, then go to ISSUE.
  - If req == 0, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - gnt and eng_start are high during this cycle only.
  - Clear timer to 0, then go to WAIT.
  - eng_done in this cycle is ignored.
- WAIT:
  - eng_op / eng_din are held stable for the whole cycle.
  - If eng_done: capture rsp_data = eng_dout, rsp_err = eng_err, rsp_timeout = 0, then go to RESP.
  - Else if timer == TIMEOUT-1: rsp_data = 0, rsp_err = 00, rsp_timeout = 1, then go to RESP.
  - Else timer++.
  - If done and timeout occur in the same cycle, done wins.
- RESP (1 cycle):
  - rsp_valid = 1 with rsp_id = latched id.
  - ptr = (id+1) mod N_REQ, wrapping from N_REQ-1 to 0.
  - Next state: IDLE.
- eng_done received in IDLE, ISSUE or RESP is ignored and produces no response.
- Requester contract:
  - Requester holds req/op/din until it samples its gnt bit, then deasserts req on the next cycle.
  - Arbitration happens only in IDLE, so there is no double grant.
- Timing:
  - Start cycle S; eng_done first sampled in cycle S+k (k>=1) gives rsp_valid in S+k+1.
  - Timeout gives rsp_valid in S+TIMEOUT+1.
  - Minimum request-to-request turnaround is 4 cycles.
- Pulses: rsp_valid, gnt and eng_start are never high for 2 consecutive cycles.
- Reset mid-operation aborts silently: no rsp_valid, and ptr returns to 0.

Test Plan:
1. Single request, encode.
   - Stimulus: req=0001, req_op[0]=0, din0=16'h0028; engine model returns done at S+3 with dout=16'h0A5C, err=00.
   - Required: gnt=0001 and eng_start for one cycle at S; eng_din=16'h0028, eng_op=0; rsp_valid at S+4 with rsp_id=0, rsp_data=16'h0A5C, rsp_timeout=0.
2. Fairness with all requesters active.
   - Stimulus: req=1111 held continuously after reset, engine done at S+1.
   - Required: grant order 0,1,2,3,0; consecutive eng_start pulses exactly 4 cycles apart.
3. Pointer skip.
   - Stimulus: after requester 2 is served, req=1011.
   - Required: next grant is requester 3, then requester 0. Requester 1 is not granted before requester 0.
4. Timeout, TIMEOUT=8.
   - Stimulus: engine never asserts done.
   - Required: rsp_valid at S+9 with rsp_timeout=1, rsp_data=0, rsp_err=00; busy drops the next cycle.
5. Done and timeout coincide.
   - Stimulus: eng_done at S+8, dout=16'h1234, err=01.
   - Required: rsp_timeout=0, rsp_data=16'h1234, rsp_err=01.
6. Reset mid-WAIT.
   - Stimulus: rst_n low at S+2, released at S+4; engine pulses done at S+5.
   - Required: all outputs 0 immediately when rst_n falls; no rsp_valid; next grant goes to the lowest-index active requester.
